// File: rtl/cursor_blink_ctrl.sv
// Cursor blink timebase, cursor position tracking and paint/erase sequencing
// of the cursor bit in the text-attribute RAM through one req/ack write port.
module cursor_blink_ctrl #(
  parameter int unsigned ClkFrequency = 32'd100_000_000,
  parameter int unsigned BlinkHz      = 32'd2,
  parameter int unsigned COLS         = 32'd80,
  parameter int unsigned ROWS         = 32'd25,
  parameter int unsigned ADDR_W       = 32'd12
) (
  input  logic              clk,
  input  logic              sync_reset,
  input  logic              cursor_en,
  input  logic              pos_valid,
  input  logic [6:0]        cursor_x,
  input  logic [4:0]        cursor_y,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_cursor,
  input  logic              wr_ack,
  output logic              blink_phase,
  output logic              cursor_drawn
);

  localparam int unsigned       PHASE_CYCLES = ClkFrequency / (32'd2 * BlinkHz);
  localparam logic [31:0]       PHASE_LAST   = 32'(PHASE_CYCLES - 32'd1);
  localparam logic [ADDR_W-1:0] COLS_A       = ADDR_W'(COLS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SET   = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nx_s;
  logic [31:0]         cnt_r;
  logic                phase_r;
  logic [ADDR_W-1:0]   tgt_addr_r;
  logic [ADDR_W-1:0]   set_addr_r;
  logic [ADDR_W-1:0]   drawn_addr_r;
  logic                drawn_r;
  logic                wr_req_r;
  logic [ADDR_W-1:0]   wr_addr_r;
  logic                wr_cursor_r;
  logic                wr_req_s;
  logic [ADDR_W-1:0]   wr_addr_s;
  logic                wr_cursor_s;
  logic                load_set_s;
  logic                pos_ok_s;
  logic [ADDR_W-1:0]   pos_addr_s;
  logic                want_s;
  logic                xfer_s;

  // An out-of-range position is dropped entirely, so only in-range loads count.
  assign pos_ok_s   = pos_valid && (32'(cursor_x) < COLS) && (32'(cursor_y) < ROWS);
  assign pos_addr_s = ADDR_W'(cursor_y) * COLS_A + ADDR_W'(cursor_x);
  assign want_s     = cursor_en & phase_r;
  assign xfer_s     = wr_req_r & wr_ack;

  // Blink timebase; a position load restarts the on-half so a moved cursor shows at once.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      cnt_r   <= 32'd0;
      phase_r <= 1'b1;
    end else if (pos_ok_s) begin
      cnt_r   <= 32'd0;
      phase_r <= 1'b1;
    end else if (cnt_r == PHASE_LAST) begin
      cnt_r   <= 32'd0;
      phase_r <= ~phase_r;
    end else begin
      cnt_r   <= cnt_r + 32'd1;
    end
  end

  // Target cell address, updated only by an in-range position strobe.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      tgt_addr_r <= {ADDR_W{1'b0}};
    end else if (pos_ok_s) begin
      tgt_addr_r <= pos_addr_s;
    end else begin
      tgt_addr_r <= tgt_addr_r;
    end
  end

  // Next state and next port values; erase always wins so an old cell is never left painted.
  always_comb begin
    state_nx_s  = state_r;
    wr_req_s    = 1'b0;
    wr_addr_s   = {ADDR_W{1'b0}};
    wr_cursor_s = 1'b0;
    load_set_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (drawn_r && (!want_s || (drawn_addr_r != tgt_addr_r))) begin
          state_nx_s  = ST_CLEAR;
          wr_req_s    = 1'b1;
          wr_addr_s   = drawn_addr_r;
          wr_cursor_s = 1'b0;
        end else if (!drawn_r && want_s) begin
          state_nx_s  = ST_SET;
          wr_req_s    = 1'b1;
          wr_addr_s   = tgt_addr_r;
          wr_cursor_s = 1'b1;
          load_set_s  = 1'b1;
        end else begin
          state_nx_s  = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (xfer_s) begin
          state_nx_s  = ST_IDLE;
        end else begin
          wr_req_s    = 1'b1;
          wr_addr_s   = drawn_addr_r;
          wr_cursor_s = 1'b0;
        end
      end
      ST_SET: begin
        if (xfer_s) begin
          state_nx_s  = ST_IDLE;
        end else begin
          wr_req_s    = 1'b1;
          wr_addr_s   = set_addr_r;
          wr_cursor_s = 1'b1;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State, registered write port and the record of what the RAM currently holds.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_r      <= ST_IDLE;
      wr_req_r     <= 1'b0;
      wr_addr_r    <= {ADDR_W{1'b0}};
      wr_cursor_r  <= 1'b0;
      set_addr_r   <= {ADDR_W{1'b0}};
      drawn_r      <= 1'b0;
      drawn_addr_r <= {ADDR_W{1'b0}};
    end else begin
      state_r     <= state_nx_s;
      wr_req_r    <= wr_req_s;
      wr_addr_r   <= wr_addr_s;
      wr_cursor_r <= wr_cursor_s;
      if (load_set_s) begin
        set_addr_r <= tgt_addr_r;
      end else begin
        set_addr_r <= set_addr_r;
      end
      if (xfer_s && (state_r == ST_CLEAR)) begin
        drawn_r <= 1'b0;
      end else if (xfer_s && (state_r == ST_SET)) begin
        drawn_r      <= 1'b1;
        drawn_addr_r <= set_addr_r;
      end else begin
        drawn_r      <= drawn_r;
      end
    end
  end

  assign wr_req       = wr_req_r;
  assign wr_addr      = wr_addr_r;
  assign wr_cursor    = wr_cursor_r;
  assign blink_phase  = phase_r;
  assign cursor_drawn = drawn_r;

endmodule

// File: tb/tb_cursor_blink_ctrl.sv
// Directed bench for cursor_blink_ctrl with a scoreboard of expected RAM writes.
module tb_cursor_blink_ctrl;

  logic        clk = 1'b0;
  logic        sync_reset;
  logic        cursor_en;
  logic        pos_valid;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic        wr_req;
  logic [11:0] wr_addr;
  logic        wr_cursor;
  logic        wr_ack;
  logic        blink_phase;
  logic        cursor_drawn;

  typedef struct {
    int          edge_i;
    logic [11:0] addr;
    logic        cur;
  } xfer_t;

  xfer_t exp_q[$];
  int    edge_n   = 0;
  int    n_checks = 0;
  int    n_fail   = 0;
  int    r0;

  cursor_blink_ctrl #(
    .ClkFrequency(32'd20),
    .BlinkHz     (32'd2),
    .COLS        (32'd80),
    .ROWS        (32'd25),
    .ADDR_W      (32'd12)
  ) dut (
    .clk         (clk),
    .sync_reset  (sync_reset),
    .cursor_en   (cursor_en),
    .pos_valid   (pos_valid),
    .cursor_x    (cursor_x),
    .cursor_y    (cursor_y),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_cursor   (wr_cursor),
    .wr_ack      (wr_ack),
    .blink_phase (blink_phase),
    .cursor_drawn(cursor_drawn)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Rising-edge index; a write accepted at edge e is recorded with edge_i = e.
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input int e, input logic [11:0] a, input logic c);
    xfer_t x;
    x.edge_i = e;
    x.addr   = a;
    x.cur    = c;
    exp_q.push_back(x);
  endtask

  task automatic to_edge(input int target);
    while (edge_n < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard: every accepted write must match the next expected one; idle port reads zero.
  always @(negedge clk) begin
    if (wr_req === 1'b1 && wr_ack === 1'b1) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL xfer_unexpected observed=edge%0d/addr%0d/cur%0b expected=none",
               edge_n + 1, wr_addr, wr_cursor);
      end
      if (exp_q.size() != 0) begin
        xfer_t e;
        e = exp_q.pop_front();
        chk("xfer_edge", 32'(edge_n + 1), 32'(e.edge_i));
        chk("xfer_addr", {20'd0, wr_addr}, {20'd0, e.addr});
        chk("xfer_cursor", {31'd0, wr_cursor}, {31'd0, e.cur});
      end
    end else if (wr_req === 1'b0) begin
      chk("idle_port_zero", {19'd0, wr_cursor, wr_addr}, 32'd0);
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Directed timeline; r0 is the last edge that sampled reset.
  initial begin
    sync_reset = 1'b1; cursor_en = 1'b0; pos_valid = 1'b0;
    cursor_x = 7'd0; cursor_y = 5'd0; wr_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    r0 = edge_n;
    chk("rst_wr_req", {31'd0, wr_req}, 32'd0);
    chk("rst_drawn", {31'd0, cursor_drawn}, 32'd0);
    chk("rst_phase", {31'd0, blink_phase}, 32'd1);
    chk("rst_port", {19'd0, wr_cursor, wr_addr}, 32'd0);
    sync_reset = 1'b0;
    cursor_en  = 1'b1;

    // Free-running blink at addr 0: phase toggles every 5 edges, drawn lags phase.
    push(r0 + 2,  12'd0, 1'b1);
    push(r0 + 7,  12'd0, 1'b0);
    push(r0 + 12, 12'd0, 1'b1);
    push(r0 + 17, 12'd0, 1'b0);
    push(r0 + 22, 12'd0, 1'b1);
    for (int m = 1; m <= 22; m++) begin
      to_edge(r0 + m);
      chk("blink_phase", {31'd0, blink_phase}, {31'd0, ((m / 5) % 2) == 0});
      chk("blink_drawn", {31'd0, cursor_drawn}, {31'd0, (m >= 2) && (((m - 2) % 10) < 5)});
    end

    // Move of a drawn cursor to (5,2): erase 0, repaint 165, blink restarted.
    push(r0 + 25, 12'd0,   1'b0);
    push(r0 + 27, 12'd165, 1'b1);
    push(r0 + 30, 12'd165, 1'b0);
    pos_valid = 1'b1; cursor_x = 7'd5; cursor_y = 5'd2;
    to_edge(r0 + 23);
    pos_valid = 1'b0;
    chk("move_phase_t", {31'd0, blink_phase}, 32'd1);
    to_edge(r0 + 25);
    chk("move_restart", {31'd0, blink_phase}, 32'd1);
    to_edge(r0 + 26);
    chk("move_drawn_gap", {31'd0, cursor_drawn}, 32'd0);
    to_edge(r0 + 27);
    chk("move_drawn_set", {31'd0, cursor_drawn}, 32'd1);
    to_edge(r0 + 28);
    chk("move_toggle_t5", {31'd0, blink_phase}, 32'd0);

    // Stalled SET: port holds while the phase drops, then an immediate CLEAR.
    to_edge(r0 + 30);
    wr_ack = 1'b0;
    push(r0 + 51, 12'd165, 1'b1);
    push(r0 + 53, 12'd165, 1'b0);
    push(r0 + 55, 12'd165, 1'b1);
    for (int k = 34; k <= 50; k++) begin
      to_edge(r0 + k);
      chk("stall_hold", {19'd0, wr_req, wr_cursor, wr_addr}, {19'd0, 1'b1, 1'b1, 12'd165});
    end
    wr_ack = 1'b1;
    chk("stall_phase_low", {31'd0, blink_phase}, 32'd0);
    to_edge(r0 + 51);
    chk("stall_drawn_a", {31'd0, cursor_drawn}, 32'd1);
    to_edge(r0 + 52);
    chk("stall_drawn_b", {31'd0, cursor_drawn}, 32'd1);
    chk("stall_clear_req", {19'd0, wr_req, wr_cursor, wr_addr}, {19'd0, 1'b1, 1'b0, 12'd165});
    to_edge(r0 + 53);
    chk("stall_drawn_c", {31'd0, cursor_drawn}, 32'd0);

    // Out-of-range positions (x=80, y=25) change nothing.
    push(r0 + 60, 12'd165, 1'b0);
    to_edge(r0 + 55);
    pos_valid = 1'b1; cursor_x = 7'd80; cursor_y = 5'd0;
    to_edge(r0 + 56);
    cursor_x = 7'd3; cursor_y = 5'd25;
    to_edge(r0 + 57);
    pos_valid = 1'b0; cursor_x = 7'd0; cursor_y = 5'd0;
    chk("oor_phase_kept", {31'd0, blink_phase}, 32'd1);
    to_edge(r0 + 58);
    chk("oor_toggle_kept", {31'd0, blink_phase}, 32'd0);

    // Disable while drawn: one CLEAR, stay dark, re-enable paints on next on-half.
    push(r0 + 65, 12'd165, 1'b1);
    push(r0 + 67, 12'd165, 1'b0);
    to_edge(r0 + 65);
    chk("dis_drawn_pre", {31'd0, cursor_drawn}, 32'd1);
    cursor_en = 1'b0;
    to_edge(r0 + 67);
    chk("dis_drawn_clr", {31'd0, cursor_drawn}, 32'd0);
    for (int k = 68; k <= 78; k++) begin
      to_edge(r0 + k);
      chk("dis_dark", {30'd0, cursor_drawn, wr_req}, 32'd0);
      chk("dis_phase", {31'd0, blink_phase}, {31'd0, (k >= 73) && (k < 78)});
    end
    cursor_en = 1'b1;
    for (int k = 79; k <= 83; k++) begin
      to_edge(r0 + k);
      chk("reen_wait", {31'd0, wr_req}, 32'd0);
    end
    wr_ack = 1'b0;
    to_edge(r0 + 84);
    chk("reen_set_req", {19'd0, wr_req, wr_cursor, wr_addr}, {19'd0, 1'b1, 1'b1, 12'd165});

    // Reset during a pending request abandons it; release repaints at addr 0.
    to_edge(r0 + 85);
    sync_reset = 1'b1;
    to_edge(r0 + 86);
    chk("mrst_wr_req", {31'd0, wr_req}, 32'd0);
    chk("mrst_drawn", {31'd0, cursor_drawn}, 32'd0);
    chk("mrst_phase", {31'd0, blink_phase}, 32'd1);
    chk("mrst_port", {19'd0, wr_cursor, wr_addr}, 32'd0);
    sync_reset = 1'b0;
    wr_ack     = 1'b1;
    push(r0 + 88, 12'd0, 1'b1);
    push(r0 + 93, 12'd0, 1'b0);
    to_edge(r0 + 87);
    chk("post_set_req", {19'd0, wr_req, wr_cursor, wr_addr}, {19'd0, 1'b1, 1'b1, 12'd0});
    to_edge(r0 + 88);
    chk("post_drawn", {31'd0, cursor_drawn}, 32'd1);
    to_edge(r0 + 90);
    chk("post_phase_on", {31'd0, blink_phase}, 32'd1);
    to_edge(r0 + 91);
    chk("post_phase_off", {31'd0, blink_phase}, 32'd0);
    to_edge(r0 + 95);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
